// File: rtl/vector_divider_32bit.sv
// rtl/vector_divider_32bit.sv - iterative SIMD restoring divider, 4x8/2x16/1x32 lanes
// One quotient bit per lane per cycle; signed ops run on magnitudes and are fixed up at the end.
module vector_divider_32bit #(
    parameter int DATA_WIDTH   = 32,
    parameter bit RISCV_CORNER = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    input  logic [1:0]            precision,
    input  logic [1:0]            opcode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result
);
    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  prec_q, prec_d, op_q, op_d;
    logic [31:0] a_q, a_d, dvd_q, dvd_d, dsr_q, dsr_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d, result_q, result_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [3:0]  negq_q, negq_d, negr_q, negr_d, dz_q, dz_d, ov_q, ov_d;

    // Per-lane flags use bit i for lane i; unused lanes read as 0.
    function automatic logic [3:0] lane_msb(input logic [31:0] x, input logic [1:0] p);
        case (p)
            2'b00:   lane_msb = {x[31], x[23], x[15], x[7]};
            2'b01:   lane_msb = {2'b00, x[31], x[15]};
            default: lane_msb = {3'b000, x[31]};
        endcase
    endfunction

    function automatic logic [3:0] lane_zero(input logic [31:0] x, input logic [1:0] p);
        case (p)
            2'b00:   lane_zero = {x[31:24] == 8'h0, x[23:16] == 8'h0, x[15:8] == 8'h0, x[7:0] == 8'h0};
            2'b01:   lane_zero = {2'b00, x[31:16] == 16'h0, x[15:0] == 16'h0};
            default: lane_zero = {3'b000, x == 32'h0};
        endcase
    endfunction

    function automatic logic [31:0] expand(input logic [3:0] f, input logic [1:0] p);
        case (p)
            2'b00:   expand = {{8{f[3]}}, {8{f[2]}}, {8{f[1]}}, {8{f[0]}}};
            2'b01:   expand = {{16{f[1]}}, {16{f[0]}}};
            default: expand = {32{f[0]}};
        endcase
    endfunction

    function automatic logic [31:0] lane_neg(input logic [31:0] x, input logic [1:0] p,
                                             input logic [3:0] en);
        logic [31:0] r;
        r = x;
        case (p)
            2'b00: for (int i = 0; i < 4; i++) if (en[i]) r[8*i +: 8] = -x[8*i +: 8];
            2'b01: for (int i = 0; i < 2; i++) if (en[i]) r[16*i +: 16] = -x[16*i +: 16];
            default: if (en[0]) r = -x;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid) state_d = S_PREP;
            S_PREP: state_d = S_ITER;
            S_ITER: if (cnt_q == 6'd0) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        result    = result_q;
    end

    always_comb begin : datapath
        logic [8:0]  t8;
        logic [16:0] t16;
        logic [32:0] t32;
        logic [3:0]  sa, sb, sgn;
        logic [31:0] qn, rn, mdz, mov, qf, rf;
        prec_d = prec_q;  op_d = op_q;  a_d = a_q;  dvd_d = dvd_q;  dsr_d = dsr_q;
        rem_d = rem_q;  quo_d = quo_q;  cnt_d = cnt_q;  result_d = result_q;
        negq_d = negq_q;  negr_d = negr_q;  dz_d = dz_q;  ov_d = ov_q;
        t8 = '0;  t16 = '0;  t32 = '0;
        sgn = {4{~op_q[0]}};
        sa = lane_msb(dvd_q, prec_q) & sgn;
        sb = lane_msb(dsr_q, prec_q) & sgn;
        qn = lane_neg(quo_q, prec_q, negq_q);
        rn = lane_neg(rem_q, prec_q, negr_q);
        mdz = expand(dz_q, prec_q);
        mov = expand(ov_q, prec_q);
        qf = qn;
        rf = rn;
        if (RISCV_CORNER) begin
            qf = (((qn & ~mdz) | mdz) & ~mov) | (a_q & mov);
            rf = ((rn & ~mdz) | (a_q & mdz)) & ~mov;
        end
        case (state_q)
            S_IDLE: if (in_valid) begin
                prec_d = (precision == 2'b11) ? 2'b10 : precision;
                op_d   = opcode;
                a_d    = dividend;
                dvd_d  = dividend;
                dsr_d  = divisor;
            end
            S_PREP: begin
                dvd_d  = lane_neg(dvd_q, prec_q, sa);
                dsr_d  = lane_neg(dsr_q, prec_q, sb);
                negq_d = sa ^ sb;
                negr_d = sa;
                dz_d   = lane_zero(dsr_q, prec_q);
                // MIN_INT: sign bit set with every other lane bit clear; -1: all lane bits set.
                ov_d   = sgn & lane_msb(dvd_q, prec_q)
                       & lane_zero(dvd_q & ~expand(4'hF, prec_q) | dvd_q & ~(prec_q == 2'b00 ? 32'h8080_8080 :
                                   prec_q == 2'b01 ? 32'h8000_8000 : 32'h8000_0000), prec_q)
                       & lane_zero(~dsr_q, prec_q);
                rem_d  = '0;
                quo_d  = '0;
                cnt_d  = (prec_q == 2'b00) ? 6'd7 : (prec_q == 2'b01) ? 6'd15 : 6'd31;
            end
            S_ITER: begin
                dvd_d = dvd_q << 1;
                cnt_d = cnt_q - 6'd1;
                case (prec_q)
                    2'b00: for (int i = 0; i < 4; i++) begin
                        t8 = {rem_q[8*i +: 8], dvd_q[8*i+7]};
                        if (t8 >= {1'b0, dsr_q[8*i +: 8]}) begin
                            rem_d[8*i +: 8] = t8[7:0] - dsr_q[8*i +: 8];
                            quo_d[8*i +: 8] = {quo_q[8*i +: 7], 1'b1};
                        end else begin
                            rem_d[8*i +: 8] = t8[7:0];
                            quo_d[8*i +: 8] = {quo_q[8*i +: 7], 1'b0};
                        end
                    end
                    2'b01: for (int i = 0; i < 2; i++) begin
                        t16 = {rem_q[16*i +: 16], dvd_q[16*i+15]};
                        if (t16 >= {1'b0, dsr_q[16*i +: 16]}) begin
                            rem_d[16*i +: 16] = t16[15:0] - dsr_q[16*i +: 16];
                            quo_d[16*i +: 16] = {quo_q[16*i +: 15], 1'b1};
                        end else begin
                            rem_d[16*i +: 16] = t16[15:0];
                            quo_d[16*i +: 16] = {quo_q[16*i +: 15], 1'b0};
                        end
                    end
                    default: begin
                        t32 = {rem_q, dvd_q[31]};
                        if (t32 >= {1'b0, dsr_q}) begin
                            rem_d = t32[31:0] - dsr_q;
                            quo_d = {quo_q[30:0], 1'b1};
                        end else begin
                            rem_d = t32[31:0];
                            quo_d = {quo_q[30:0], 1'b0};
                        end
                    end
                endcase
            end
            S_FIX: result_d = op_q[1] ? rf : qf;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prec_q <= '0;  op_q <= '0;  a_q <= '0;  dvd_q <= '0;  dsr_q <= '0;
            rem_q <= '0;  quo_q <= '0;  cnt_q <= '0;  result_q <= '0;
            negq_q <= '0;  negr_q <= '0;  dz_q <= '0;  ov_q <= '0;
        end else begin
            prec_q <= prec_d;  op_q <= op_d;  a_q <= a_d;  dvd_q <= dvd_d;  dsr_q <= dsr_d;
            rem_q <= rem_d;  quo_q <= quo_d;  cnt_q <= cnt_d;  result_q <= result_d;
            negq_q <= negq_d;  negr_q <= negr_d;  dz_q <= dz_d;  ov_q <= ov_d;
        end
    end
endmodule
